// File: rtl/zynq_axil_pkg.sv
// Shared response codes, channel FSM states and the byte-strobe merge helper
// for the PS->PL AXI4-Lite CSR responder.
package zynq_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/zynq_axil_csr_decode.sv
// Word-index decoder for the CSR responder address map: CSRs, then status
// words, then FIFO_DATA and FIFO_CTRL; everything above is unmapped.
module zynq_axil_csr_decode
    import zynq_axil_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int num_csr_p    = 4,
    parameter int num_status_p = 4
) (
    input  logic [addr_width_p-3:0] word_idx,
    output logic                    is_csr,
    output logic                    is_status,
    output logic                    is_fifo_data,
    output logic                    is_fifo_ctrl,
    output logic                    unmapped,
    output logic [addr_width_p-3:0] local_idx
);

    localparam int idx_w = addr_width_p - 2;
    localparam logic [idx_w-1:0] STATUS_BASE   = idx_w'(num_csr_p);
    localparam logic [idx_w-1:0] FIFO_DATA_IDX = idx_w'(num_csr_p + num_status_p);
    localparam logic [idx_w-1:0] FIFO_CTRL_IDX = idx_w'(num_csr_p + num_status_p + 1);

    assign is_csr       = (word_idx < STATUS_BASE);
    assign is_status    = (word_idx >= STATUS_BASE) && (word_idx < FIFO_DATA_IDX);
    assign is_fifo_data = (word_idx == FIFO_DATA_IDX);
    assign is_fifo_ctrl = (word_idx == FIFO_CTRL_IDX);
    assign unmapped     = (word_idx > FIFO_CTRL_IDX);

    // Status words are numbered from zero relative to the end of the CSR block.
    assign local_idx = is_status ? (word_idx - STATUS_BASE) : word_idx;

endmodule

// File: rtl/zynq_axil_csr_responder.sv
// AXI4-Lite responder for the top_zynq s00_axi control port: RW CSRs, RO status
// words and a pop-on-read FIFO port. ZYNQ_AXIL_CSR_SLVERR_EN enables SLVERR replies.
module zynq_axil_csr_responder
    import zynq_axil_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int data_width_p = 32,
    parameter int num_csr_p    = 4,
    parameter int num_status_p = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [addr_width_p-1:0]            s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [data_width_p-1:0]            s_axi_wdata,
    input  logic [3:0]                         s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [addr_width_p-1:0]            s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [data_width_p-1:0]            s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [num_csr_p*data_width_p-1:0]  csr_data_o,
    output logic [num_csr_p-1:0]               csr_wr_o,
    input  logic [num_status_p*data_width_p-1:0] status_i,
    input  logic [data_width_p-1:0]            fifo_data_i,
    input  logic                               fifo_v_i,
    output logic                               fifo_yumi_o
);

    localparam int idx_w = addr_width_p - 2;

`ifdef ZYNQ_AXIL_CSR_SLVERR_EN
    localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

    wr_state_e               wr_state;
    rd_state_e               rd_state;
    logic [data_width_p-1:0] csr_q [num_csr_p];
    logic [idx_w-1:0]        aw_idx_q;
    logic [data_width_p-1:0] wdata_q;
    logic [3:0]              wstrb_q;

    logic                    aw_hs, w_hs, ar_hs, wr_commit;
    logic [idx_w-1:0]        wr_word_idx, wr_lidx, rd_lidx;
    logic [data_width_p-1:0] wr_data;
    logic [3:0]              wr_strb;
    logic                    wr_is_csr;
    logic [3:0]              unused_wr_flags;
    logic                    rd_is_csr, rd_is_status, rd_is_fifo_data, rd_is_fifo_ctrl, rd_unmapped;
    logic [data_width_p-1:0] rd_word;
    logic [1:0]              rd_resp;
    logic                    unused_inputs;

    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The commit edge may coincide with either handshake, so take whichever
    // half arrives this cycle straight from the bus rather than from the latch.
    assign wr_word_idx = aw_hs ? s_axi_awaddr[addr_width_p-1:2] : aw_idx_q;
    assign wr_data     = w_hs ? s_axi_wdata : wdata_q;
    assign wr_strb     = w_hs ? s_axi_wstrb : wstrb_q;
    assign wr_commit   = ((wr_state == W_IDLE)    && aw_hs && w_hs) ||
                         ((wr_state == W_WAIT_W)  && w_hs) ||
                         ((wr_state == W_WAIT_AW) && aw_hs);

    zynq_axil_csr_decode #(
        .addr_width_p (addr_width_p),
        .num_csr_p    (num_csr_p),
        .num_status_p (num_status_p)
    ) u_wr_decode (
        .word_idx     (wr_word_idx),
        .is_csr       (wr_is_csr),
        .is_status    (unused_wr_flags[0]),
        .is_fifo_data (unused_wr_flags[1]),
        .is_fifo_ctrl (unused_wr_flags[2]),
        .unmapped     (unused_wr_flags[3]),
        .local_idx    (wr_lidx)
    );

    zynq_axil_csr_decode #(
        .addr_width_p (addr_width_p),
        .num_csr_p    (num_csr_p),
        .num_status_p (num_status_p)
    ) u_rd_decode (
        .word_idx     (s_axi_araddr[addr_width_p-1:2]),
        .is_csr       (rd_is_csr),
        .is_status    (rd_is_status),
        .is_fifo_data (rd_is_fifo_data),
        .is_fifo_ctrl (rd_is_fifo_ctrl),
        .unmapped     (rd_unmapped),
        .local_idx    (rd_lidx)
    );

    // NOTE: the CSR array is a handful of flops, not a RAM, and software expects
    // zero after reset, so it is reset explicitly; state uses <= so every
    // branch below sees pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state      <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            csr_wr_o      <= '0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            for (int i = 0; i < num_csr_p; i++) csr_q[i] <= '0;
        end else begin
            csr_wr_o <= '0;
            if (aw_hs) aw_idx_q <= s_axi_awaddr[addr_width_p-1:2];
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (wr_commit) begin
                for (int i = 0; i < num_csr_p; i++) begin
                    if (wr_is_csr && (wr_lidx == idx_w'(i))) begin
                        csr_q[i]    <= apply_wstrb(csr_q[i], wr_data, wr_strb);
                        csr_wr_o[i] <= 1'b1;
                    end
                end
                s_axi_bresp <= wr_is_csr ? RESP_OKAY : ERR_RESP;
            end
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state      <= W_RESP;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state      <= W_WAIT_W;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                    end else if (w_hs) begin
                        wr_state      <= W_WAIT_AW;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b0;
                    end else begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                W_WAIT_W: begin
                    if (w_hs) begin
                        wr_state     <= W_RESP;
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                    end
                end
                W_WAIT_AW: begin
                    if (aw_hs) begin
                        wr_state      <= W_RESP;
                        s_axi_awready <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        wr_state      <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: defaults first so no path through the mux leaves a latch behind.
    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (rd_is_csr) begin
            for (int i = 0; i < num_csr_p; i++) begin
                if (rd_lidx == idx_w'(i)) rd_word = csr_q[i];
            end
        end else if (rd_is_status) begin
            for (int i = 0; i < num_status_p; i++) begin
                if (rd_lidx == idx_w'(i)) rd_word = status_i[data_width_p*i +: data_width_p];
            end
        end else if (rd_is_fifo_data) begin
            if (fifo_v_i) rd_word = fifo_data_i;
            else          rd_resp = ERR_RESP;
        end else if (rd_is_fifo_ctrl) begin
            rd_word = {{(data_width_p-1){1'b0}}, fifo_v_i};
        end else if (rd_unmapped) begin
            rd_resp = ERR_RESP;
        end
    end

    // Pop only in the cycle the read is accepted, so the popped word is the one returned.
    assign fifo_yumi_o = ar_hs && rd_is_fifo_data && fifo_v_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= R_RESP;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_word;
                        s_axi_rresp   <= rd_resp;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rd_state      <= R_IDLE;
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < num_csr_p; g++) begin : g_csr_out
        assign csr_data_o[data_width_p*g +: data_width_p] = csr_q[g];
    end

endmodule

// File: tb/tb_zynq_axil_csr_responder.sv
// Directed bench for zynq_axil_csr_responder: write/read scoreboards, FIFO pops,
// response codes (follow ZYNQ_AXIL_CSR_SLVERR_EN) and mid-response reset.
`timescale 1ns/1ps
module tb_zynq_axil_csr_responder;

    localparam int AW = 10;
    localparam int NC = 4;
    localparam int NS = 4;

    localparam logic [1:0] OKAY = 2'b00;
`ifdef ZYNQ_AXIL_CSR_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW-1:0]     s_axi_awaddr = '0;
    logic [2:0]        s_axi_awprot = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [AW-1:0]     s_axi_araddr = '0;
    logic [2:0]        s_axi_arprot = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic [NC*32-1:0]  csr_data_o;
    logic [NC-1:0]     csr_wr_o;
    logic [NS*32-1:0]  status_i = '0;
    logic [31:0]       fifo_data_i = '0;
    logic              fifo_v_i = 1'b0;
    logic              fifo_yumi_o;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic [1:0] b_q[$];
    rd_exp_t    r_q[$];
    int compared = 0;
    int mismatched = 0;

    zynq_axil_csr_responder #(
        .addr_width_p (AW),
        .data_width_p (32),
        .num_csr_p    (NC),
        .num_status_p (NS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .csr_data_o    (csr_data_o),
        .csr_wr_o      (csr_wr_o),
        .status_i      (status_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_v_i      (fifo_v_i),
        .fifo_yumi_o   (fifo_yumi_o)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] csr(input int i);
        return csr_data_o[32*i +: 32];
    endfunction

    // Drives AW and W (W leads by w_lead cycles) and returns #1 after the commit edge.
    task automatic send_write(input logic [AW-1:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int w_lead, input logic [1:0] exp_resp);
        int  cyc;
        bit  aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 0; w_done = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
            cyc++;
            if (!aw_done && cyc >= w_lead) s_axi_awvalid = 1'b1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("write_handshake", {aw_done, w_done}, 2'b11);
        b_q.push_back(exp_resp);
    endtask

    task automatic collect_b(input int delay);
        int         cyc;
        bit         got;
        logic [1:0] exp;
        for (int d = 0; d < delay; d++) begin
            check("bvalid_held", s_axi_bvalid, 1'b1);
            check("awready_in_resp", s_axi_awready, 1'b0);
            check("wready_in_resp", s_axi_wready, 1'b0);
            @(posedge aclk); #1;
        end
        s_axi_bready = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge aclk);
            got = s_axi_bvalid;
            if (got) begin
                exp = (b_q.size() > 0) ? b_q.pop_front() : 2'bxx;
                check("bresp", s_axi_bresp, exp);
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axi_bready = 1'b0;
        check("b_handshake", got, 1'b1);
        check("bvalid_drop", s_axi_bvalid, 1'b0);
    endtask

    task automatic issue_ar(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, output int yumi);
        int      cyc;
        bit      fired;
        rd_exp_t e;
        e.data = exp_data;
        e.resp = exp_resp;
        r_q.push_back(e);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        yumi = 0; cyc = 0; fired = 0;
        while (!fired && cyc < 50) begin
            @(negedge aclk);
            fired = s_axi_arvalid && s_axi_arready;
            if (fifo_yumi_o) yumi++;
            @(posedge aclk); #1;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        check("ar_handshake", fired, 1'b1);
    endtask

    task automatic collect_r(input int delay);
        int      cyc;
        bit      got;
        rd_exp_t e;
        for (int d = 0; d < delay; d++) begin
            check("rvalid_held", s_axi_rvalid, 1'b1);
            check("arready_in_resp", s_axi_arready, 1'b0);
            if (r_q.size() > 0) check("rdata_stable", s_axi_rdata, r_q[0].data);
            @(posedge aclk); #1;
        end
        s_axi_rready = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge aclk);
            got = s_axi_rvalid;
            if (got) begin
                if (r_q.size() > 0) e = r_q.pop_front();
                else                e = 'x;
                check("rdata", s_axi_rdata, e.data);
                check("rresp", s_axi_rresp, e.resp);
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("r_handshake", got, 1'b1);
        check("rvalid_drop", s_axi_rvalid, 1'b0);
    endtask

    task automatic read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp, input int exp_yumi, input int delay);
        int yumi;
        issue_ar(addr, exp_data, exp_resp, yumi);
        check("fifo_pop_count", yumi, exp_yumi);
        collect_r(delay);
    endtask

    initial begin
        status_i = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'hCAFE_0001};
        repeat (3) @(posedge aclk);
        #1;
        check("reset_awready", s_axi_awready, 1'b0);
        check("reset_wready", s_axi_wready, 1'b0);
        check("reset_arready", s_axi_arready, 1'b0);
        check("reset_bvalid", s_axi_bvalid, 1'b0);
        check("reset_rvalid", s_axi_rvalid, 1'b0);
        check("reset_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
        check("reset_csrs", csr_data_o, '0);
        check("reset_csr_wr", csr_wr_o, '0);
        check("reset_yumi", fifo_yumi_o, 1'b0);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // AW and W together
        send_write(10'h004, 32'hDEAD_BEEF, 4'hF, 0, OKAY);
        check("bvalid_latency", s_axi_bvalid, 1'b1);
        check("csr_wr_pulse_csr1", csr_wr_o, 4'b0010);
        check("csr1_after_write", csr(1), 32'hDEAD_BEEF);
        collect_b(0);
        check("csr_wr_pulse_end", csr_wr_o, 4'b0000);

        // W two cycles ahead of AW, partial strobes
        send_write(10'h000, 32'hFFFF_FFFF, 4'hF, 0, OKAY);
        collect_b(0);
        send_write(10'h000, 32'h1122_3344, 4'h3, 2, OKAY);
        check("csr_wr_pulse_csr0", csr_wr_o, 4'b0001);
        collect_b(0);
        check("csr0_strobed", csr(0), 32'hFFFF_3344);

        // Stalled B channel, then a zero-strobe write
        send_write(10'h008, 32'h1234_5678, 4'hF, 0, OKAY);
        collect_b(5);
        check("csr2_after_write", csr(2), 32'h1234_5678);
        send_write(10'h00C, 32'hFFFF_FFFF, 4'h0, 0, OKAY);
        check("csr_wr_pulse_zero_strb", csr_wr_o, 4'b1000);
        collect_b(0);
        check("csr3_zero_strb", csr(3), 32'h0);

        // Status and CSR reads
        read(10'h010, 32'hCAFE_0001, OKAY, 0, 0);
        read(10'h01C, 32'h4444_0003, OKAY, 0, 3);
        read(10'h004, 32'hDEAD_BEEF, OKAY, 0, 0);

        // FIFO port
        fifo_data_i = 32'h0000_00A5;
        fifo_v_i    = 1'b1;
        read(10'h020, 32'h0000_00A5, OKAY, 1, 0);
        read(10'h024, 32'h0000_0001, OKAY, 0, 0);
        fifo_v_i    = 1'b0;
        read(10'h020, 32'h0, ERR, 0, 0);
        read(10'h024, 32'h0, OKAY, 0, 0);

        // Unmapped reads
        read(10'h028, 32'h0, ERR, 0, 0);
        read(10'h3FC, 32'h0, ERR, 0, 0);

        // Write to a status word leaves state alone
        send_write(10'h010, 32'h0BAD_0BAD, 4'hF, 0, ERR);
        check("csr_wr_pulse_status_write", csr_wr_o, 4'b0000);
        collect_b(0);
        check("csr1_unchanged", csr(1), 32'hDEAD_BEEF);
        read(10'h010, 32'hCAFE_0001, OKAY, 0, 0);

        // AR and write commit to the same CSR in one cycle: read sees the old value
        begin
            rd_exp_t e;
            e.data = 32'h1234_5678;
            e.resp = OKAY;
            r_q.push_back(e);
            b_q.push_back(OKAY);
            s_axi_awaddr = 10'h008; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
            s_axi_araddr = 10'h008;
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
            @(negedge aclk);
            check("all_ready_same_cycle", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
            @(posedge aclk); #1;
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
            check("csr2_new_value", csr(2), 32'h0BAD_F00D);
            collect_b(0);
            collect_r(0);
        end

        // Reset while a write response is pending
        send_write(10'h004, 32'h0000_0055, 4'hF, 0, OKAY);
        check("bvalid_before_reset", s_axi_bvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("bvalid_in_reset", s_axi_bvalid, 1'b0);
        check("csrs_in_reset", csr_data_o, '0);
        check("awready_in_reset", s_axi_awready, 1'b0);
        b_q.delete();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        read(10'h004, 32'h0, OKAY, 0, 0);
        send_write(10'h00C, 32'hA5A5_5A5A, 4'hF, 0, OKAY);
        collect_b(0);
        check("csr3_after_reset_write", csr(3), 32'hA5A5_5A5A);

        check("scoreboard_drained", b_q.size() + r_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
